// File: rtl/pipe_ctrl_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_unit_if
//  Brief    : Signal bundle between the pipeline control unit and the
//             datapath. The control unit takes the master side: it receives
//             ID/EX status and drives every stage control. The datapath
//             takes the slave side.
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_unit_if #(
    parameter int RA_W = 4
);
    // ID/EX status from the datapath
    logic [3:0]      opcode_id;
    logic [RA_W-1:0] rs_id;
    logic [RA_W-1:0] rt_id;
    logic [RA_W-1:0] rd_ex;
    logic [1:0]      branch_result;
    logic            overflow_ex;

    // Front-end (PC / IF / ID) controls
    logic            pc_write;
    logic            ifid_write;
    logic            if_flush;
    logic            id_flush;
    logic            pc_op;
    logic            b_jmp;

    // Per-stage controls
    logic [1:0]      ex_alu_op;
    logic [1:0]      ex_mux_a;
    logic [1:0]      ex_mux_b;
    logic            mem_byte_en;
    logic            mem_write;
    logic            wb_mux_c;
    logic [1:0]      wb_reg_write;
    logic            wb_r0_select;

    // Status
    logic            exc_take;
    logic            ovf_status;
    logic            halted;

    modport master (
        input  opcode_id, rs_id, rt_id, rd_ex, branch_result, overflow_ex,
        output pc_write, ifid_write, if_flush, id_flush, pc_op, b_jmp,
        output ex_alu_op, ex_mux_a, ex_mux_b, mem_byte_en, mem_write,
        output wb_mux_c, wb_reg_write, wb_r0_select,
        output exc_take, ovf_status, halted
    );

    modport slave (
        output opcode_id, rs_id, rt_id, rd_ex, branch_result, overflow_ex,
        input  pc_write, ifid_write, if_flush, id_flush, pc_op, b_jmp,
        input  ex_alu_op, ex_mux_a, ex_mux_b, mem_byte_en, mem_write,
        input  wb_mux_c, wb_reg_write, wb_r0_select,
        input  exc_take, ovf_status, halted
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_unit
//  Brief    : Pipelined control unit for the 16-bit five-stage CPU. Decodes
//             the ID opcode into a control bundle, carries it through EX, MEM
//             and WB, and generates load-use stalls, branch/jump flushes and
//             the halt drain sequence.
//             Optional feature macro: PIPE_CTRL_OVF_TRAP_EN enables the ALU
//             overflow trap (exc_take pulse, sticky ovf_status).
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl_unit #(
    parameter int RA_W       = 4,
    parameter int HALT_DRAIN = 3
) (
    input  logic             clk,
    input  logic             reset,
    pipe_ctrl_unit_if.master bus
);

    // Control bundle carried down the pipe; r0_select rides along to WB
    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] mux_a;
        logic [1:0] mux_b;
        logic       mux_c;
        logic [1:0] reg_write;
        logic       byte_en;
        logic       mem_write;
        logic       r0_select;
    } bundle_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [2:0]      c_drain_load = 3'(HALT_DRAIN);
    localparam logic [RA_W-1:0] c_reg_zero   = '0;

    localparam logic [3:0] c_op_halt  = 4'b0000;
    localparam logic [3:0] c_op_andi  = 4'b0001;
    localparam logic [3:0] c_op_ori   = 4'b0010;
    localparam logic [3:0] c_op_bgt   = 4'b0100;
    localparam logic [3:0] c_op_blt   = 4'b0101;
    localparam logic [3:0] c_op_beq   = 4'b0110;
    localparam logic [3:0] c_op_jmp   = 4'b0111;
    localparam logic [3:0] c_op_lbu   = 4'b1010;
    localparam logic [3:0] c_op_sb    = 4'b1011;
    localparam logic [3:0] c_op_lw    = 4'b1100;
    localparam logic [3:0] c_op_sw    = 4'b1101;
    localparam logic [3:0] c_op_rtype = 4'b1111;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_next;

    bundle_t    r_ex;
    bundle_t    r_mem;
    bundle_t    r_wb;
    bundle_t    w_dec;
    bundle_t    w_ex_next;
    bundle_t    w_mem_next;

    logic       w_ex_load;
    logic       w_stall;
    logic       w_br_taken;
    logic       w_jmp;
    logic       w_halt_id;
    logic       w_exc;
    logic       r_ovf;

    logic       w_pc_write;
    logic       w_ifid_write;
    logic       w_if_flush;
    logic       w_id_flush;
    logic       w_pc_op;
    logic       w_b_jmp;

    // Opcode decode into the control bundle; unlisted opcodes give a bubble
    always_comb begin
        w_dec = '0;
        case (bus.opcode_id)
            c_op_rtype: begin
                w_dec.alu_op    = 2'b01;
                w_dec.mux_c     = 1'b1;
                w_dec.reg_write = 2'b11;
            end
            c_op_andi: begin
                w_dec.alu_op    = 2'b00;
                w_dec.mux_b     = 2'b11;
                w_dec.mux_c     = 1'b1;
                w_dec.reg_write = 2'b11;
            end
            c_op_ori: begin
                w_dec.alu_op    = 2'b10;
                w_dec.mux_b     = 2'b11;
                w_dec.mux_c     = 1'b1;
                w_dec.reg_write = 2'b11;
            end
            c_op_lbu: begin
                w_dec.alu_op    = 2'b11;
                w_dec.mux_a     = 2'b11;
                w_dec.reg_write = 2'b11;
                w_dec.byte_en   = 1'b1;
            end
            c_op_sb: begin
                w_dec.alu_op    = 2'b11;
                w_dec.mux_a     = 2'b11;
                w_dec.byte_en   = 1'b1;
                w_dec.mem_write = 1'b1;
            end
            c_op_lw: begin
                w_dec.alu_op    = 2'b11;
                w_dec.mux_a     = 2'b11;
                w_dec.reg_write = 2'b11;
            end
            c_op_sw: begin
                w_dec.alu_op    = 2'b11;
                w_dec.mux_a     = 2'b11;
                w_dec.mem_write = 1'b1;
            end
            default: begin
                w_dec = '0;
            end
        endcase
    end

    // Loads are the only register writers that take WB data from memory
    assign w_ex_load = (r_ex.reg_write == 2'b11) && !r_ex.mux_c;

    assign w_stall = w_ex_load && (bus.rd_ex != c_reg_zero) &&
                     ((bus.rd_ex == bus.rs_id) || (bus.rd_ex == bus.rt_id));

    assign w_br_taken = ((bus.opcode_id == c_op_beq) && (bus.branch_result == 2'b01)) ||
                        ((bus.opcode_id == c_op_bgt) && (bus.branch_result == 2'b10)) ||
                        ((bus.opcode_id == c_op_blt) && (bus.branch_result == 2'b11));
    assign w_jmp      = (bus.opcode_id == c_op_jmp);
    assign w_halt_id  = (bus.opcode_id == c_op_halt);

`ifdef PIPE_CTRL_OVF_TRAP_EN
    // Trap only a result-writing, non-store instruction that overflowed
    assign w_exc = reset && bus.overflow_ex &&
                   (r_ex.reg_write == 2'b11) && !r_ex.mem_write;

    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_exc) begin
            r_ovf <= 1'b1;
        end
    end
`else
    assign w_exc = 1'b0;
    assign r_ovf = 1'b0;
`endif

    // Next state, drain counter, front-end controls and the bundle entering EX
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pc_write   = 1'b1;
        w_ifid_write = 1'b1;
        w_if_flush   = 1'b0;
        w_id_flush   = 1'b0;
        w_pc_op      = 1'b0;
        w_b_jmp      = 1'b0;
        w_ex_next    = w_dec;

        case (r_state)
            ST_RUN: begin
                if (w_halt_id && !w_stall && !w_exc) begin
                    w_state_next = ST_DRAIN;
                    w_cnt_next   = c_drain_load;
                end
            end
            ST_DRAIN: begin
                w_cnt_next = r_cnt - 3'd1;
                if (r_cnt <= 3'd1) begin
                    w_state_next = ST_HALTED;
                end
            end
            default: begin
                w_state_next = ST_HALTED;
            end
        endcase

        if (w_exc) begin
            w_if_flush = 1'b1;
            w_id_flush = 1'b1;
            w_pc_write = 1'b1;
            w_ex_next  = '0;
        end else if (r_state != ST_RUN) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_id_flush   = 1'b1;
            w_ex_next    = '0;
        end else if (w_stall) begin
            // Hold PC and IF/ID; branch evaluation is suppressed this cycle
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_id_flush   = 1'b1;
            w_ex_next    = '0;
        end else if (w_halt_id) begin
            w_pc_write = 1'b0;
            w_if_flush = 1'b1;
            w_id_flush = 1'b1;
            w_ex_next  = '0;
        end else if (w_br_taken || w_jmp) begin
            w_pc_op             = 1'b1;
            w_b_jmp             = w_br_taken;
            w_if_flush          = 1'b1;
            w_id_flush          = 1'b1;
            w_ex_next           = '0;
            w_ex_next.r0_select = 1'b1;
        end

        // Reset overrides the front end so nothing is fetched while held
        if (!reset) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_if_flush   = 1'b1;
            w_id_flush   = 1'b1;
            w_pc_op      = 1'b0;
            w_b_jmp      = 1'b0;
        end
    end

    // A trapped instruction keeps flowing but loses its register write
    always_comb begin
        w_mem_next = r_ex;
        if (w_exc) begin
            w_mem_next.reg_write = 2'b00;
        end
    end

    // State register, drain counter and EX/MEM/WB bundle registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_cnt   <= 3'd0;
            r_ex    <= '0;
            r_mem   <= '0;
            r_wb    <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ex    <= w_ex_next;
            r_mem   <= w_mem_next;
            r_wb    <= r_mem;
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.ifid_write   = w_ifid_write;
    assign bus.if_flush     = w_if_flush;
    assign bus.id_flush     = w_id_flush;
    assign bus.pc_op        = w_pc_op;
    assign bus.b_jmp        = w_b_jmp;

    assign bus.ex_alu_op    = r_ex.alu_op;
    assign bus.ex_mux_a     = r_ex.mux_a;
    assign bus.ex_mux_b     = r_ex.mux_b;
    assign bus.mem_byte_en  = r_mem.byte_en;
    assign bus.mem_write    = r_mem.mem_write;
    assign bus.wb_mux_c     = r_wb.mux_c;
    assign bus.wb_reg_write = r_wb.reg_write;
    assign bus.wb_r0_select = r_wb.r0_select;

    assign bus.exc_take     = w_exc;
    assign bus.ovf_status   = r_ovf;
    assign bus.halted       = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined control unit for the 16-bit five-stage CPU. It decodes the ID-stage opcode into a control bundle and carries that bundle through registered EX, MEM and WB stages. It also owns load-use stall detection, branch/jump flush generation, a halt drain state machine, and an optional overflow trap. It sits beside the datapath pipeline registers and drives every stage's muxes, enables and flushes.

## Interface
- RA_W, 4, register-address width for the hazard compare.
- HALT_DRAIN, 3, cycles to drain EX/MEM/WB after a halt is decoded (1..7).
- clk  in  1  pipeline clock.
- reset  in  1  reset, synchronous, active-low.
- opcode_id  in  4  opcode of the instruction in ID.
- rs_id, rt_id  in  RA_W  source registers of the ID instruction.
- rd_ex  in  RA_W  destination register of the EX instruction.
- branch_result  in  2  ID comparator: 01 eq, 10 gt, 11 lt, 00 none.
- overflow_ex  in  1  ALU overflow for the EX instruction.
- pc_write, ifid_write  out  1  PC and IF/ID register enables.
- if_flush, id_flush  out  1  clear IF/ID; insert a bubble into EX.
- pc_op, b_jmp  out  1  PC source: taken redirect; branch (1) vs jump (0) target.
- ex_alu_op, ex_mux_a, ex_mux_b  out  2  EX-stage controls.
- mem_byte_en, mem_write  out  1  MEM-stage controls.
- wb_mux_c  out  1; wb_reg_write  out  2; wb_r0_select  out  1  WB-stage controls.
- exc_take  out  1  one-cycle overflow-trap redirect pulse.
- ovf_status  out  1  sticky overflow flag.
- halted  out  1  core stopped.

## Operation
- Decode table (opcode: alu_op, mux_a, mux_b, mux_c, reg_write, byte_en, mem_write):
  - 1111 R-type: 01,00,00,1,11,0,0.
  - 0001 andi: 00,00,11,1,11,0,0.
  - 0010 ori: 10,00,11,1,11,0,0.
  - 1010 lbu: 11,11,00,0,11,1,0.
  - 1011 sb: 11,11,00,0,00,1,1.
  - 1100 lw: 11,11,00,0,11,0,0.
  - 1101 sw: 11,11,00,0,00,0,1.
  - Branches, jmp, halt and undefined opcodes produce an all-zero bundle. Branches never set mem_write.
- Branch taken when the opcode/result pair is 0110/01, 0100/10 or 0101/11. Response: pc_op=1, b_jmp=1, if_flush=1, id_flush=1, and wb_r0_select=1 on the branch's bubble. jmp (0111) gives the same response with b_jmp=0.
- Load-use stall applies when the EX instruction is lbu or lw, rd_ex != 0, and rd_ex equals rs_id or rt_id. Response: pc_write=0, ifid_write=0, bubble into EX, branch evaluation suppressed (pc_op=0).
- FSM states:
  - RUN → DRAIN when halt (0000) is in ID and no stall is active. The halt itself becomes a bubble; if_flush=1; pc_write=0; the counter loads HALT_DRAIN.
  - DRAIN: pc_write=0, ifid_write=0, bubbles inserted into EX; the counter decrements each cycle. Counter==1 → HALTED.
  - HALTED: halted=1, pc_write=0, all stage bundles zero. Only reset exits.
- Priority: reset > exc_take > DRAIN/HALTED > load-use stall > branch/jmp > normal.
- Wrap-around: EX bundle → MEM → WB each cycle. The WB bundle is dropped after one cycle.

## Timing
- Reset (reset=0 at a rising edge):
  - All stage bundles, ovf_status, exc_take and halted clear to 0; state returns to RUN.
  - While reset is low: pc_write=0, ifid_write=0, if_flush=1, id_flush=1, pc_op=0, b_jmp=0.
  - Reset during DRAIN or HALTED returns to RUN on the next edge.
- Flush and PC controls (pc_write, ifid_write, if_flush, id_flush, pc_op, b_jmp) are combinational from ID inputs and state within the same cycle.
- Stage control latency from the ID cycle: EX outputs at +1, MEM at +2, WB at +3.
- Halt: halted rises HALT_DRAIN+1 cycles after the halt is in ID. The last pre-halt instruction's WB completes before halted=1.

## Configuration
- PIPE_CTRL_OVF_TRAP_EN defined:
  - overflow_ex=1 with a valid ALU bundle (reg_write=11, mem_write=0) in EX forces reg_write=00 into MEM.
  - exc_take=1 for that cycle; if_flush=1, id_flush=1, pc_write=1.
  - ovf_status sets and holds until reset.
- Undefined: overflow_ex is ignored; exc_take and ovf_status are tied 0.

## Test plan
- Reset: hold reset=0 for 2 cycles with opcode_id=1111 → all stage outputs 0, if_flush=1. First edge after release gives ex_alu_op=01 and, 2 cycles later, wb_reg_write=11.
- Load-use: lw with rd_ex=3 in EX, R-type with rs_id=3 in ID → pc_write=0, ifid_write=0, next ex_* all 0. rd_ex=0 → no stall.
- Branch: opcode 0101 with branch_result=11 → pc_op=1, b_jmp=1, if_flush=1; next EX bundle zero. branch_result=10 → pc_op=0.
- Halt: HALT_DRAIN=3, halt in ID after sw, lw → pc_write=0 from that cycle; mem_write=1 then 0; halted=1 four cycles later; stays until reset.
- Trap (macro on): andi in EX with overflow_ex=1 → exc_take=1 for one cycle, MEM-stage wb_reg_write=00, ovf_status=1 held. Macro off → reg_write=11 propagates, exc_take=0.
